// File: rtl/weight_pkg.sv
// Shared types and default dimensions for the weight loader and weight storage benches.
package weight_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        FINISH
    } loader_state_t;

    localparam int FRAC_BITS  = 8;
    localparam int DATA_SIZE  = 16;
    localparam int SIZE       = 3;
    localparam int LAYER_SIZE = 5;

endpackage

// File: rtl/weight_loader_if.sv
// Weight word input stream plus the storage write port driven by the loader.
interface weight_loader_if
    import weight_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int size      = SIZE
);
    logic [data_size-1:0]      in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               write_layer_index;
    logic [31:0]               write_row_index;
    logic [data_size*size-1:0] write_data;
    logic                      is_write;

    modport master (
        input  in_data, in_valid,
        output in_ready, write_layer_index, write_row_index, write_data, is_write
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, write_layer_index, write_row_index, write_data, is_write
    );
endinterface

// File: rtl/weight_loader_row_packer.sv
// Packs successive words into one row, column 0 in the MSB slice.
// Latency: row shows the accepted word combinationally; slices update on the accept edge.
// Backpressure: none of its own; load is the caller's accepted-word strobe.
module row_packer
    import weight_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int size      = SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      load,
    input  logic [data_size-1:0]      word,
    output logic [data_size*size-1:0] row,
    output logic                      full
);
    localparam int CW = (size > 1) ? $clog2(size) : 1;

    logic [CW-1:0]             col;
    logic [data_size*size-1:0] slices;
    int                        sel;

    assign full = (32'(col) == size - 1);

    // Merging the incoming word lets the caller capture a complete row on the last accept.
    always_comb begin
        sel = (size - int'(col)) * data_size - 1;
        row = slices;
        if (load) begin
            row[sel -: data_size] = word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            col    <= '0;
            slices <= '0;
        end else if (load) begin
            slices <= row;
            col    <= full ? '0 : col + CW'(1);
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Streams Q8.8 words into rows and writes every row of every layer into weight storage.
// Latency: size+1 cycles per row minimum, done pulses one cycle after the final write.
// Backpressure: in_ready high only while filling; in_valid low stalls indefinitely. Checksum: WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader
    import weight_pkg::*;
#(
    parameter int data_size  = DATA_SIZE,
    parameter int size       = SIZE,
    parameter int layer_size = LAYER_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    weight_loader_if.master     wif,
    output logic                busy,
    output logic                done,
    output logic [31:0]         checksum
);
    localparam int RW = (size > 1) ? $clog2(size) : 1;
    localparam int LW = (layer_size > 1) ? $clog2(layer_size) : 1;

    loader_state_t             state;
    logic [RW-1:0]             row_cnt;
    logic [LW-1:0]             layer_cnt;
    logic                      accept;
    logic                      start_ok;
    logic                      full;
    logic [data_size*size-1:0] packed_row;

    assign accept   = (state == FILL) && wif.in_valid && wif.in_ready;
    assign start_ok = (state == IDLE) && start;

    row_packer #(
        .data_size(data_size),
        .size     (size)
    ) u_packer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(start_ok),
        .load (accept),
        .word (wif.in_data),
        .row  (packed_row),
        .full (full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                 <= IDLE;
            wif.in_ready          <= 1'b0;
            wif.is_write          <= 1'b0;
            wif.write_data        <= '0;
            wif.write_row_index   <= '0;
            wif.write_layer_index <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            row_cnt               <= '0;
            layer_cnt             <= '0;
        end else begin
            wif.is_write <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= FILL;
                        wif.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        row_cnt      <= '0;
                        layer_cnt    <= '0;
                    end
                end
                FILL: begin
                    if (accept && full) begin
                        state                 <= WRITE;
                        wif.in_ready          <= 1'b0;
                        wif.is_write          <= 1'b1;
                        wif.write_data        <= packed_row;
                        wif.write_row_index   <= 32'(row_cnt);
                        wif.write_layer_index <= 32'(layer_cnt);
                    end
                end
                WRITE: begin
                    if (32'(row_cnt) < size - 1) begin
                        row_cnt      <= row_cnt + RW'(1);
                        state        <= FILL;
                        wif.in_ready <= 1'b1;
                    end else if (32'(layer_cnt) < layer_size - 1) begin
                        row_cnt      <= '0;
                        layer_cnt    <= layer_cnt + LW'(1);
                        state        <= FILL;
                        wif.in_ready <= 1'b1;
                    end else begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + 32'($signed(wif.in_data));
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule
